spi_slave_if: RTL and testbench
===============================

// Module: spi_slave_if
// PURPOSE
//   SPI slave front end that feeds the single-port RAM. It deserialises 10-bit
//   command frames (MSB first) from MOSI into rx_data and pulses rx_valid. On a
//   read-data command it takes the RAM's tx_data/tx_valid reply and shifts it out
//   on MISO. Mode 0: MOSI is sampled and MISO is updated on the rising clk edge.
// PARAMETERS
//   TX_W   8   width of the read-back data word; the RX frame is TX_W+2 bits
// PORTS
//   clk       in   1       SPI serial clock; the only clock in the block
//   rst       in   1       synchronous reset, active-high
//   ss_n      in   1       slave select, active-low; high terminates any frame
//   mosi      in   1       serial data in, MSB first
//   miso      out  1       serial data out, MSB first; 0 when not transmitting
//   rx_data   out  TX_W+2  received frame; [9:8]=cmd, [7:0]=addr/data
//   rx_valid  out  1       one-cycle pulse; rx_data is valid while this is high
//   tx_data   in   TX_W    read data from the RAM
//   tx_valid  in   1       tx_data is valid; sampled only in READ_DATA after rx_valid
// BEHAVIOUR
//   Clocking and reset
//   - One clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
//   - rst=1 at an edge: state=IDLE; rx_data=0; rx_valid=0; miso=0; rd_addr_ok=0; counters=0.
//   - rst asserted mid-frame or mid-readout aborts the operation. No partial rx_valid is produced.
//   States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA
//   - Any state with ss_n=1 at an edge -> IDLE next cycle; miso=0; bit count cleared.
//     rd_addr_ok is kept, so a read-address frame can be followed by a separate read-data frame.
//   - IDLE: ss_n=0 -> CHK_CMD. No bit is sampled on this edge.
//   - CHK_CMD: sample mosi as frame bit 9.
//     - mosi=0 -> WRITE.
//     - mosi=1 and rd_addr_ok=0 -> READ_ADD.
//     - mosi=1 and rd_addr_ok=1 -> READ_DATA.
//   Frame reception
//   - WRITE, READ_ADD and READ_DATA each shift in the remaining 9 bits (bits 8..0).
//   - On the edge that samples bit 0: rx_data <= full frame; rx_valid <= 1 for exactly one cycle.
//   - In IDLE, edge E0 sees ss_n=0. Bits are sampled on E1..E10. rx_valid is high in the cycle after E10.
//   - rx_data holds its value until the next complete frame.
//   - MOSI bits after bit 0 are ignored until ss_n rises.
//   - rx_data[9:8] is forwarded as received. The block never rewrites the cmd bits.
//   - READ_ADD: on frame completion, rd_addr_ok <= 1.
//   Read-back (READ_DATA)
//   - After rx_valid, wait for tx_valid=1. At the first such edge T:
//     - load the tx shift register with tx_data;
//     - miso <= tx_data[TX_W-1].
//   - Edges T+1..T+TX_W-1 shift out the lower bits, MSB first.
//   - At edge T+TX_W: miso <= 0, rd_addr_ok <= 0, and tx_valid is ignored for the rest of the frame.
//   - If ss_n rises before the word completes, the readout aborts and rd_addr_ok is kept (read may be retried).
//   - tx_valid outside this window is ignored.
//   Boundary conditions
//   - A frame cut short by ss_n (<10 bits) produces no rx_valid and does not change rx_data.
//   - Back-to-back frames need ss_n high for at least one edge (IDLE) between them.
//   - ss_n=0 held continuously after a frame completes stays in the current state. No second frame is taken.
// TESTING
//   1. Write addr: ss_n=0, send 0x0A5 (00_1010_0101) ->
//      rx_data=0x0A5, one rx_valid pulse after the 10th bit edge; miso=0 throughout.
//   2. Write data: send 0x13C -> rx_valid pulse, rx_data=0x13C, state=WRITE, rd_addr_ok unchanged (0).
//   3. Read: send 0x2F0 (READ_ADD, rd_addr_ok->1), release ss_n, then send 0x300 (READ_DATA) ->
//      after rx_valid, model tx_data=0xC3 with tx_valid ->
//      miso = 1,1,0,0,0,0,1,1 on the following 8 edges, then 0; rd_addr_ok=0.
//   4. Abort: ss_n rises after 6 bits of 0x055 -> no rx_valid, rx_data keeps its old value, state=IDLE next cycle.
//   5. Reset mid-readout: rst=1 after 3 miso bits ->
//      miso=0, rx_valid=0, state=IDLE, rd_addr_ok=0; the next 0x3xx frame goes to READ_ADD.
//   6. Spurious tx_valid=1 during a WRITE frame -> miso stays 0, no state change.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end for the single-port RAM: deserialises 10-bit command frames
// and shifts the RAM's read-back word out on MISO. Debug state encoding: 0 IDLE, 1 CHK_CMD, 2 WRITE, 3 READ_ADD, 4 READ_DATA.
module spi_slave_if #(
  parameter int TX_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic [TX_W+1:0]   rx_data,
  output logic              rx_valid,
  input  logic [TX_W-1:0]   tx_data,
  input  logic              tx_valid,
  output logic [2:0]        dbg_state_o,
  output logic              dbg_rd_addr_ok_o
);

  localparam int FRAME_W = TX_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TXC_W   = $clog2(TX_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] FRAME_DONE = CNT_W'(FRAME_W);
  localparam logic [TXC_W-1:0] TX_LAST    = TXC_W'(TX_W);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e               state_q;
  logic [FRAME_W-2:0]   shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [FRAME_W-1:0]   rx_data_q;
  logic                 rx_valid_q;
  logic                 miso_q;
  logic                 rd_addr_ok_q;
  logic [TX_W-1:0]      tx_shift_q;
  logic [TXC_W-1:0]     tx_cnt_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
      rd_addr_ok_q <= 1'b0;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (ss_n) begin
        // rd_addr_ok survives deselect so a read-data frame can follow a read-address frame
        state_q   <= IDLE;
        miso_q    <= 1'b0;
        bit_cnt_q <= '0;
        tx_cnt_q  <= '0;
        tx_busy_q <= 1'b0;
        tx_done_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: state_q <= CHK_CMD;
          CHK_CMD: begin
            shift_q   <= {{(FRAME_W-2){1'b0}}, mosi};
            bit_cnt_q <= CNT_W'(1);
            if (!mosi)             state_q <= WRITE;
            else if (!rd_addr_ok_q) state_q <= READ_ADD;
            else                    state_q <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (bit_cnt_q < FRAME_DONE) begin
              shift_q   <= {shift_q[FRAME_W-3:0], mosi};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) begin
                rx_data_q  <= {shift_q, mosi};
                rx_valid_q <= 1'b1;
                if (state_q == READ_ADD) rd_addr_ok_q <= 1'b1;
              end
            end else if (state_q == READ_DATA && !tx_done_q) begin
              if (!tx_busy_q) begin
                if (tx_valid) begin
                  miso_q     <= tx_data[TX_W-1];
                  tx_shift_q <= {tx_data[TX_W-2:0], 1'b0};
                  tx_cnt_q   <= TXC_W'(1);
                  tx_busy_q  <= 1'b1;
                end
              end else if (tx_cnt_q < TX_LAST) begin
                miso_q     <= tx_shift_q[TX_W-1];
                tx_shift_q <= {tx_shift_q[TX_W-2:0], 1'b0};
                tx_cnt_q   <= tx_cnt_q + 1'b1;
              end else begin
                miso_q       <= 1'b0;
                rd_addr_ok_q <= 1'b0;
                tx_busy_q    <= 1'b0;
                tx_done_q    <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso             = miso_q;
  assign rx_data          = rx_data_q;
  assign rx_valid         = rx_valid_q;
  assign dbg_state_o      = state_q;
  assign dbg_rd_addr_ok_o = rd_addr_ok_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed plus randomized frames for spi_slave_if, checked against a frame-level model
// (expected rx word, read-address flag, queue of expected MISO bits).
module tb_spi_slave_if;

  localparam int TX_W = 8;
  localparam int FW   = TX_W + 2;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHK   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_RADD  = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  logic            clk = 1'b0;
  logic            rst, ss_n, mosi, miso, rx_valid, tx_valid, dbg_rd_ok;
  logic [FW-1:0]   rx_data;
  logic [TX_W-1:0] tx_data;
  logic [2:0]      dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [FW-1:0] m_rx_data;
  logic          m_rd_ok;
  logic [0:0]    exp_q[$];

  spi_slave_if #(.TX_W(TX_W)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .dbg_state_o(dbg_state), .dbg_rd_addr_ok_o(dbg_rd_ok)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] kind_of(input logic b9, input logic ok);
    if (!b9) return S_WRITE;
    return ok ? S_RDATA : S_RADD;
  endfunction

  // drivers
  task automatic do_reset();
    rst = 1'b1; tx_valid = 1'b0;
    tick();
    m_rd_ok = 1'b0; m_rx_data = '0; exp_q.delete();
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_miso", miso, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    chk("rst_rdok", dbg_rd_ok, 0);
    rst = 1'b0;
  endtask

  task automatic release_ss();
    ss_n = 1'b1; tx_valid = 1'($urandom_range(0, 1)); mosi = 1'($urandom_range(0, 1));
    tick();
    chk("rel_state", dbg_state, S_IDLE);
    chk("rel_miso", miso, 0);
    chk("rel_rxv", rx_valid, 0);
    chk("rel_rdok", dbg_rd_ok, m_rd_ok);
    chk("rel_rxd", rx_data, m_rx_data);
    tx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [FW-1:0] f, input int nbits, output logic [2:0] kind);
    kind = kind_of(f[FW-1], m_rd_ok);
    ss_n = 1'b0; mosi = 1'($urandom_range(0, 1));
    tick();
    chk("e0_state", dbg_state, S_CHK);
    chk("e0_rxv", rx_valid, 0);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[FW-1-i];
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = TX_W'($urandom);
      tick();
      chk("rx_miso", miso, 0);
      if (i == 0) chk("cmd_state", dbg_state, kind);
      if (i == FW-1) begin
        chk("rxv_pulse", rx_valid, 1);
        chk("rx_data", rx_data, f);
      end else begin
        chk("rxv_quiet", rx_valid, 0);
        chk("rx_hold", rx_data, m_rx_data);
      end
    end
    if (nbits == FW) begin
      m_rx_data = f;
      if (kind == S_RADD) m_rd_ok = 1'b1;
      chk("frame_rdok", dbg_rd_ok, m_rd_ok);
    end
    tx_valid = 1'b0;
  endtask

  // ss_n held low after a complete frame: extra bits and tx_valid are ignored
  task automatic hold_low(input int n, input logic [2:0] kind);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom_range(0, 1));
      tx_valid = (kind == S_RDATA) ? 1'b0 : 1'($urandom_range(0, 1));
      tx_data = TX_W'($urandom);
      tick();
      chk("hold_state", dbg_state, kind);
      chk("hold_rxv", rx_valid, 0);
      chk("hold_miso", miso, 0);
      chk("hold_rxd", rx_data, m_rx_data);
    end
    tx_valid = 1'b0;
  endtask

  task automatic readout(input logic [TX_W-1:0] d, input int wait_cyc, input int nbits_out);
    tx_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      mosi = 1'($urandom_range(0, 1));
      tick();
      chk("pre_miso", miso, 0);
      chk("pre_rxv", rx_valid, 0);
    end
    exp_q.delete();
    for (int b = TX_W-1; b >= 0; b--) exp_q.push_back(d[b]);
    tx_valid = 1'b1; tx_data = d;
    for (int i = 0; i < nbits_out; i++) begin
      tick();
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = TX_W'($urandom);
      chk("miso_bit", miso, exp_q.pop_front());
    end
    if (nbits_out == TX_W) begin
      tick();
      m_rd_ok = 1'b0;
      chk("miso_end", miso, 0);
      chk("rdok_clr", dbg_rd_ok, m_rd_ok);
      for (int i = 0; i < 2; i++) begin
        tx_valid = 1'b1; tx_data = TX_W'($urandom);
        tick();
        chk("post_miso", miso, 0);
      end
    end
    tx_valid = 1'b0;
  endtask

  // directed sequence, then randomized frames
  initial begin
    logic [2:0]      k;
    logic [FW-1:0]   f;
    int              nb, ab;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick();
    do_reset();
    tick();

    send_frame(10'h0A5, FW, k); release_ss();
    send_frame(10'h13C, FW, k);
    hold_low(4, k);
    release_ss();

    send_frame(10'h2F0, FW, k); release_ss();
    send_frame(10'h300, FW, k);
    readout(8'hC3, 2, TX_W);
    release_ss();

    send_frame(10'h055, 6, k); release_ss();

    send_frame(10'h2F0, FW, k); release_ss();
    send_frame(10'h3A5, FW, k);
    readout(8'h5A, 1, 3);
    do_reset();
    release_ss();
    send_frame(10'h3C7, FW, k); release_ss();

    for (int n = 0; n < 60; n++) begin
      f  = FW'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FW-1)) : FW;
      send_frame(f, nb, k);
      if (nb == FW && k == S_RDATA) begin
        ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TX_W-1)) : TX_W;
        readout(TX_W'($urandom), int'($urandom_range(0, 3)), ab);
      end else if (nb == FW) begin
        hold_low(int'($urandom_range(0, 2)), k);
      end
      release_ss();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
